// File: rtl/cpu_defs.sv
// Shared definitions for the memory-port arbiter and the CPU datapath.
package cpu_defs;

   localparam int unsigned AW_DEF = 16;
   localparam int unsigned DW_DEF = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_LDR = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported main memory between the CPU and the program loader.
// One access in flight at a time, fixed latency, CPU priority with a bound on
// how many CPU grants in a row may pass a waiting loader.
module mem_port_arbiter
   import cpu_defs::*;
#(
   parameter int unsigned AW         = AW_DEF,
   parameter int unsigned DW         = DW_DEF,
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic          CLK,
   input  logic          Reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_ack,
   output logic          cpu_stall,
   input  logic          ldr_req,
   input  logic          ldr_we,
   input  logic [AW-1:0] ldr_addr,
   input  logic [DW-1:0] ldr_wdata,
   output logic [DW-1:0] ldr_rdata,
   output logic          ldr_ack,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT);
   localparam logic [3:0] STARVE_TOP = 4'(STARVE_MAX);

   state_t        state_q, state_d;
   owner_t        own_q, own_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [2:0]    lat_q, lat_d;
   logic [3:0]    starve_q, starve_d;
   logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DW-1:0] ldr_rdata_q, ldr_rdata_d;
   logic          ldr_wins;
   logic          issue;

   // State and datapath registers, synchronous reset.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q     <= IDLE;
         own_q       <= OWN_CPU;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         lat_q       <= '0;
         starve_q    <= '0;
         cpu_rdata_q <= '0;
         ldr_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         own_q       <= own_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         lat_q       <= lat_d;
         starve_q    <= starve_d;
         cpu_rdata_q <= cpu_rdata_d;
         ldr_rdata_q <= ldr_rdata_d;
      end
   end

   // Next-state: arbitration in IDLE, latency countdown in WAIT, capture on exit.
   always_comb begin
      state_d     = state_q;
      own_d       = own_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      lat_d       = lat_q;
      starve_d    = starve_q;
      cpu_rdata_d = cpu_rdata_q;
      ldr_rdata_d = ldr_rdata_q;
      ldr_wins    = ldr_req & (~cpu_req | (starve_q == STARVE_TOP));

      case (state_q)
         IDLE: begin
            if (!ldr_req) starve_d = '0;
            if (ldr_wins) begin
               own_d    = OWN_LDR;
               we_d     = ldr_we;
               addr_d   = ldr_addr;
               wdata_d  = ldr_wdata;
               starve_d = '0;
               state_d  = ISSUE;
            end else if (cpu_req) begin
               own_d   = OWN_CPU;
               we_d    = cpu_we;
               addr_d  = cpu_addr;
               wdata_d = cpu_wdata;
               // A CPU grant with the loader waiting implies starve_q < STARVE_TOP,
               // so the increment saturates by construction.
               if (ldr_req) starve_d = starve_q + 4'd1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            lat_d   = LAT_INIT;
            state_d = WAIT;
         end
         WAIT: begin
            lat_d = lat_q - 3'd1;
            if (lat_q == 3'd1) begin
               if (own_q == OWN_CPU) cpu_rdata_d = mem_rdata;
               else                  ldr_rdata_d = mem_rdata;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign issue     = (state_q == ISSUE);
   assign busy      = (state_q != IDLE);
   assign mem_en    = issue;
   assign mem_we    = issue & we_q;
   assign mem_addr  = issue ? addr_q : '0;
   assign mem_wdata = issue ? wdata_q : '0;
   assign cpu_ack   = (state_q == DONE) & (own_q == OWN_CPU);
   assign ldr_ack   = (state_q == DONE) & (own_q == OWN_LDR);
   assign cpu_stall = cpu_req & ~cpu_ack;
   assign cpu_rdata = cpu_rdata_q;
   assign ldr_rdata = ldr_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=1/STARVE_MAX=4 and
// MEM_LAT=3/STARVE_MAX=2), each with its own latency-pipelined memory, checked
// every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int unsigned AW   = 16;
   localparam int unsigned DW   = 16;
   localparam int unsigned LAT0 = 1;
   localparam int unsigned LAT1 = 3;
   localparam int unsigned SM0  = 4;
   localparam int unsigned SM1  = 2;

   logic          CLK = 1'b0;
   logic          rst       [2];
   logic          cpu_req   [2];
   logic          cpu_we    [2];
   logic [AW-1:0] cpu_addr  [2];
   logic [DW-1:0] cpu_wdata [2];
   logic [DW-1:0] cpu_rdata [2];
   logic          cpu_ack   [2];
   logic          cpu_stall [2];
   logic          ldr_req   [2];
   logic          ldr_we    [2];
   logic [AW-1:0] ldr_addr  [2];
   logic [DW-1:0] ldr_wdata [2];
   logic [DW-1:0] ldr_rdata [2];
   logic          ldr_ack   [2];
   logic          mem_en    [2];
   logic          mem_we    [2];
   logic [AW-1:0] mem_addr  [2];
   logic [DW-1:0] mem_wdata [2];
   logic [DW-1:0] mem_rdata [2];
   logic          busy      [2];

   always #5 CLK = ~CLK;

   mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT0), .STARVE_MAX(SM0)) u_dut0 (
      .CLK(CLK), .Reset(rst[0]),
      .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
      .cpu_rdata(cpu_rdata[0]), .cpu_ack(cpu_ack[0]), .cpu_stall(cpu_stall[0]),
      .ldr_req(ldr_req[0]), .ldr_we(ldr_we[0]), .ldr_addr(ldr_addr[0]), .ldr_wdata(ldr_wdata[0]),
      .ldr_rdata(ldr_rdata[0]), .ldr_ack(ldr_ack[0]),
      .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
      .mem_rdata(mem_rdata[0]), .busy(busy[0]));

   mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT1), .STARVE_MAX(SM1)) u_dut1 (
      .CLK(CLK), .Reset(rst[1]),
      .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
      .cpu_rdata(cpu_rdata[1]), .cpu_ack(cpu_ack[1]), .cpu_stall(cpu_stall[1]),
      .ldr_req(ldr_req[1]), .ldr_we(ldr_we[1]), .ldr_addr(ldr_addr[1]), .ldr_wdata(ldr_wdata[1]),
      .ldr_rdata(ldr_rdata[1]), .ldr_ack(ldr_ack[1]),
      .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
      .mem_rdata(mem_rdata[1]), .busy(busy[1]));

   // Initial memory image; 0x0040 holds 0xBEEF in both memories.
   function automatic logic [DW-1:0] init_word(input int k, input int a);
      if (a == 'h40) return 16'hBEEF;
      return 16'((a * 'h0101) ^ ((k + 1) * 'h3C3C));
   endfunction

   // Memory: samples on the edge ending the ISSUE cycle, data valid MEM_LAT
   // edges later, zero otherwise so an early or late capture is visible.
   logic [DW-1:0] mem  [2][256];
   logic [DW-1:0] pipe [2][8];
   logic          mem_init = 1'b0;
   always @(posedge CLK) begin
      if (!mem_init) begin
         for (int k = 0; k < 2; k++)
            for (int a = 0; a < 256; a++) mem[k][a] <= init_word(k, a);
         mem_init <= 1'b1;
      end else begin
         for (int k = 0; k < 2; k++)
            if (mem_en[k] && mem_we[k]) mem[k][mem_addr[k][7:0]] <= mem_wdata[k];
      end
      for (int k = 0; k < 2; k++) begin
         pipe[k][0] <= mem_en[k] ? mem[k][mem_addr[k][7:0]] : '0;
         for (int j = 1; j < 8; j++) pipe[k][j] <= pipe[k][j-1];
      end
   end
   assign mem_rdata[0] = pipe[0][LAT0-1];
   assign mem_rdata[1] = pipe[1][LAT1-1];

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   // Reference model (per instance): one transaction in flight, granted in
   // cycle g_cyc, acked in g_cyc+LAT+2, arbiter free again at g_cyc+LAT+3.
   int            g_cyc   [2];
   int            g_own   [2];
   logic          g_we    [2];
   logic [AW-1:0] g_addr  [2];
   logic [DW-1:0] g_wdata [2];
   logic [DW-1:0] g_rd    [2];
   int            starve  [2];
   logic [DW-1:0] refmem  [2][256];
   bit            rd_known[2][2];
   logic [DW-1:0] rd_exp  [2][2];
   bit            rst_req [2];

   // Requesters: [k][0]=CPU, [k][1]=loader.
   bit            d_act   [2][2];
   logic          d_we    [2][2];
   logic [AW-1:0] d_addr  [2][2];
   logic [DW-1:0] d_wdata [2][2];
   int            d_rem   [2][2];
   bit            d_rand  [2][2];
   int            d_gap   [2][2];
   bit            d_acked [2][2];
   bit            d_start [2][2];

   function automatic int lat_of(input int k);
      return (k == 0) ? int'(LAT0) : int'(LAT1);
   endfunction
   function automatic int sm_of(input int k);
      return (k == 0) ? int'(SM0) : int'(SM1);
   endfunction

   task automatic chk(input int k, input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL u%0d.%s @cyc %0d: observed %0h expected %0h", k, tag, cyc, obs, exp);
   endtask

   task automatic new_txn(input int k, input int r);
      d_act[k][r]   = 1'b1;
      d_we[k][r]    = 1'($urandom_range(0, 1));
      d_addr[k][r]  = 16'($urandom) & 16'hF00F;
      d_wdata[k][r] = 16'($urandom);
   endtask

   task automatic issue(input int k, input int r, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input int rem);
      d_we[k][r]    = we;
      d_addr[k][r]  = a;
      d_wdata[k][r] = wd;
      d_rem[k][r]   = rem;
      d_start[k][r] = 1'b1;
   endtask

   task automatic drive(input int k);
      for (int r = 0; r < 2; r++) begin
         if (d_acked[k][r]) begin
            d_acked[k][r] = 1'b0;
            if (d_rem[k][r] > 0) begin
               d_rem[k][r]--;
               new_txn(k, r);
            end else if (d_rand[k][r] && $urandom_range(0, 2) == 0) begin
               new_txn(k, r);
            end else begin
               d_act[k][r] = 1'b0;
               d_gap[k][r] = $urandom_range(0, 4);
            end
         end else if (!d_act[k][r] && d_rand[k][r]) begin
            if (d_gap[k][r] == 0) new_txn(k, r);
            else d_gap[k][r]--;
         end
         if (d_start[k][r]) begin
            d_start[k][r] = 1'b0;
            d_act[k][r]   = 1'b1;
         end
      end
      rst[k]       = rst_req[k];
      cpu_req[k]   = d_act[k][0];
      cpu_we[k]    = d_we[k][0];
      cpu_addr[k]  = d_addr[k][0];
      cpu_wdata[k] = d_wdata[k][0];
      ldr_req[k]   = d_act[k][1];
      ldr_we[k]    = d_we[k][1];
      ldr_addr[k]  = d_addr[k][1];
      ldr_wdata[k] = d_wdata[k][1];
   endtask

   task automatic grant(input int k, input int r);
      g_cyc[k]   = cyc;
      g_own[k]   = r;
      g_we[k]    = d_we[k][r];
      g_addr[k]  = d_addr[k][r];
      g_wdata[k] = d_wdata[k][r];
      if (d_we[k][r]) refmem[k][d_addr[k][r][7:0]] = d_wdata[k][r];
      else            g_rd[k] = refmem[k][d_addr[k][r][7:0]];
   endtask

   task automatic model_cycle(input int k);
      bit infl, iss, dn, c, l;
      infl = (g_cyc[k] >= 0);
      iss  = infl && (cyc == g_cyc[k] + 1);
      dn   = infl && (cyc == g_cyc[k] + lat_of(k) + 2);
      if (dn) begin
         rd_known[k][g_own[k]] = !g_we[k];
         rd_exp[k][g_own[k]]   = g_rd[k];
      end
      chk(k, "cpu_ack",   cpu_ack[k],   dn && g_own[k] == 0);
      chk(k, "ldr_ack",   ldr_ack[k],   dn && g_own[k] == 1);
      chk(k, "cpu_stall", cpu_stall[k], d_act[k][0] && !(dn && g_own[k] == 0));
      chk(k, "busy",      busy[k],      infl && cyc > g_cyc[k]);
      chk(k, "mem_en",    mem_en[k],    iss);
      chk(k, "mem_we",    mem_we[k],    iss && g_we[k]);
      chk(k, "mem_addr",  mem_addr[k],  iss ? g_addr[k] : 16'h0);
      chk(k, "mem_wdata", mem_wdata[k], iss ? g_wdata[k] : 16'h0);
      if (rd_known[k][0]) chk(k, "cpu_rdata", cpu_rdata[k], rd_exp[k][0]);
      if (rd_known[k][1]) chk(k, "ldr_rdata", ldr_rdata[k], rd_exp[k][1]);

      if (rst[k]) begin
         g_cyc[k]  = -1;
         starve[k] = 0;
         for (int r = 0; r < 2; r++) begin
            rd_known[k][r] = 1'b1;
            rd_exp[k][r]   = '0;
            d_act[k][r]    = 1'b0;
            d_rem[k][r]    = 0;
            d_acked[k][r]  = 1'b0;
         end
      end else if (dn) begin
         d_acked[k][g_own[k]] = 1'b1;
         g_cyc[k] = -1;
      end else if (!infl) begin
         c = d_act[k][0];
         l = d_act[k][1];
         if (!l) starve[k] = 0;
         if (l && (!c || starve[k] == sm_of(k))) begin
            grant(k, 1);
            starve[k] = 0;
         end else if (c) begin
            grant(k, 0);
            if (l && starve[k] < sm_of(k)) starve[k]++;
         end
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
      cyc++;
      for (int k = 0; k < 2; k++) drive(k);
      #1;
      for (int k = 0; k < 2; k++) model_cycle(k);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1);
   end

   initial begin
      int    ca, la, a1, a2;
      string ord;

      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b1;  rst_req[k] = 1'b0;
         cpu_req[k] = 1'b0; cpu_we[k] = 1'b0; cpu_addr[k] = '0; cpu_wdata[k] = '0;
         ldr_req[k] = 1'b0; ldr_we[k] = 1'b0; ldr_addr[k] = '0; ldr_wdata[k] = '0;
         g_cyc[k] = -1; starve[k] = 0; g_rd[k] = '0; g_we[k] = 1'b0;
         g_addr[k] = '0; g_wdata[k] = '0; g_own[k] = 0;
         for (int a = 0; a < 256; a++) refmem[k][a] = init_word(k, a);
         for (int r = 0; r < 2; r++) begin
            d_act[k][r] = 1'b0; d_we[k][r] = 1'b0; d_addr[k][r] = '0; d_wdata[k][r] = '0;
            d_rem[k][r] = 0; d_rand[k][r] = 1'b0; d_gap[k][r] = 0;
            d_acked[k][r] = 1'b0; d_start[k][r] = 1'b0;
            rd_known[k][r] = 1'b1; rd_exp[k][r] = '0;
         end
      end
      repeat (10) @(posedge CLK);

      // Reset state.
      step();
      for (int k = 0; k < 2; k++) begin
         chk(k, "rst_busy",  busy[k],      1'b0);
         chk(k, "rst_acks",  {cpu_ack[k], ldr_ack[k]}, 2'b00);
         chk(k, "rst_memen", mem_en[k],    1'b0);
         chk(k, "rst_rdata", {cpu_rdata[k], ldr_rdata[k]}, 32'h0);
      end

      // CPU read of 0x0040, MEM_LAT=1.
      issue(0, 0, 1'b0, 16'h0040, 16'h0, 0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk(0, "t1_mem_en", mem_en[0],    i == 1);
         chk(0, "t1_ack",    cpu_ack[0],   i == 3);
         chk(0, "t1_stall",  cpu_stall[0], i < 3);
         if (i == 3) chk(0, "t1_rdata", cpu_rdata[0], 16'hBEEF);
      end

      // Loader write [0x0010]=0x1234, then CPU read-back.
      issue(0, 1, 1'b1, 16'h0010, 16'h1234, 0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk(0, "t2_ldr_ack", ldr_ack[0], i == 3);
         chk(0, "t2_mem_we",  mem_we[0],  i == 1);
      end
      issue(0, 0, 1'b0, 16'h0010, 16'h0, 0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk(0, "t2_cpu_we", mem_we[0], 1'b0);
         if (i == 3) chk(0, "t2_rdata", cpu_rdata[0], 16'h1234);
      end

      // Simultaneous first requests: CPU first, loader MEM_LAT+3 later.
      ca = -1; la = -1;
      issue(0, 0, 1'b0, 16'h0003, 16'h0, 0);
      issue(0, 1, 1'b0, 16'h0004, 16'h0, 0);
      for (int i = 0; i < 10; i++) begin
         step();
         if (cpu_ack[0] === 1'b1) ca = i;
         if (ldr_ack[0] === 1'b1) la = i;
      end
      chk(0, "t3_cpu_ack_cyc", ca, 3);
      chk(0, "t3_ldr_ack_cyc", la, 3 + LAT0 + 3);

      // Both requesters held: 8 CPU and 2 loader transactions.
      ord = "";
      issue(0, 0, 1'b0, 16'h0001, 16'h0, 7);
      issue(0, 1, 1'b0, 16'h0002, 16'h0, 1);
      for (int i = 0; i < 48; i++) begin
         step();
         chk(0, "t4_ack_excl", cpu_ack[0] & ldr_ack[0], 1'b0);
         if (cpu_ack[0] === 1'b1) ord = {ord, "C"};
         if (ldr_ack[0] === 1'b1) ord = {ord, "L"};
      end
      n_chk++;
      assert (ord == "CCCCLCCCCL") n_pass++;
      else $error("FAIL u0.t4_grant_order: observed %s expected CCCCLCCCCL", ord);

      // MEM_LAT=3, back-to-back CPU reads.
      a1 = -1; a2 = -1;
      issue(1, 0, 1'b0, 16'h0005, 16'h0, 0);
      for (int i = 0; i < 13; i++) begin
         if (i == 6) issue(1, 0, 1'b0, 16'h0009, 16'h0, 0);
         step();
         if (cpu_ack[1] === 1'b1) begin
            if (a1 < 0) a1 = i; else a2 = i;
         end
         if (i == 5)  chk(1, "t5_rdata_a", cpu_rdata[1], init_word(1, 5));
         if (i == 11) chk(1, "t5_rdata_b", cpu_rdata[1], init_word(1, 9));
      end
      chk(1, "t5_first_ack", a1, LAT1 + 2);
      chk(1, "t5_ack_gap",   a2 - a1, LAT1 + 3);

      // Reset during WAIT aborts; a re-issued request completes.
      issue(1, 0, 1'b0, 16'h0007, 16'h0, 0);
      for (int i = 0; i < 5; i++) begin
         rst_req[1] = (i == 3);
         step();
         if (i == 4) begin
            chk(1, "t6_busy",  busy[1], 1'b0);
            chk(1, "t6_acks",  {cpu_ack[1], ldr_ack[1]}, 2'b00);
            chk(1, "t6_rdata", cpu_rdata[1], 16'h0);
         end
      end
      rst_req[1] = 1'b0;
      issue(1, 0, 1'b0, 16'h0007, 16'h0, 0);
      for (int i = 0; i < 8; i++) begin
         step();
         chk(1, "t6_reissue_ack", cpu_ack[1], i == LAT1 + 2);
         if (i == LAT1 + 2) chk(1, "t6_reissue_rdata", cpu_rdata[1], init_word(1, 7));
      end

      // Random traffic on both instances, then drain.
      for (int k = 0; k < 2; k++)
         for (int r = 0; r < 2; r++) begin
            d_rand[k][r] = 1'b1;
            d_gap[k][r]  = $urandom_range(0, 3);
         end
      repeat (600) step();
      for (int k = 0; k < 2; k++)
         for (int r = 0; r < 2; r++) d_rand[k][r] = 1'b0;
      repeat (40) step();
      for (int k = 0; k < 2; k++) chk(k, "drain_idle", busy[k], 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
